mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter and sequencer sharing one single-port synchronous memory between instruction fetch (IF) and the data-memory access issued by the ID/EX control path. Accepts the active-low DmemREB/DmemWEB strobes produced for LW/SW, sequences one memory transaction at a time with a fixed read latency, and returns data with a one-cycle valid pulse. Drives per-requester stall signals back to the pipeline.

## Interface
- ADDR_W, 32, address width for both requesters and memory
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from the memory enable cycle to MemRdata valid (legal range 1..7)

- CLK  in  1  clock, all state on rising edge
- RST  in  1  synchronous, active-high reset
- IfReq  in  1  fetch read request, held until IfValid
- IfAddr  in  ADDR_W  fetch address, stable while IfReq
- IfRdata  out  DATA_W  fetched word, meaningful when IfValid
- IfValid  out  1  one-cycle completion pulse for fetch
- IfStall  out  1  IfReq & ~IfValid
- DmemREB  in  1  data read request, active low
- DmemWEB  in  1  data write request, active low
- DmemAddr  in  ADDR_W  data address (ALU result)
- DmemWdata  in  DATA_W  store data
- DmemRdata  out  DATA_W  load data, meaningful when DmemValid
- DmemValid  out  1  one-cycle completion pulse for data access
- DmemStall  out  1  (~DmemREB | ~DmemWEB) & ~DmemValid
- MemEn  out  1  memory access strobe, one cycle per transaction
- MemWe  out  1  write qualifier, valid with MemEn
- MemAddr  out  ADDR_W  memory address
- MemWdata  out  DATA_W  memory write data
- MemRdata  in  DATA_W  memory read data, valid MEM_LAT cycles after MemEn

## Operation
- Data request active when DmemREB==0 or DmemWEB==0; both low is illegal and is treated as a write (read ignored).
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: sample requests. None -> stay. One -> grant it. Both -> grant the one not granted last (LastGrant); LastGrant resets to IF, so data wins the first tie. Go ISSUE, register Owner, Mem* outputs.
- ISSUE: MemEn=1 for exactly this cycle, MemWe=1 only for a data write. Write -> RESP. Read -> WAIT, load counter with MEM_LAT.
- WAIT: decrement counter; in the cycle MemRdata is valid (counter==1), capture into the owner's Rdata register and go RESP.
- RESP: owner's Valid=1 for this one cycle, update LastGrant=Owner; go IDLE. Requests are not sampled in RESP, so a request still high in the Valid cycle is never re-issued.
- Requesters must keep address/data stable and request asserted until their Valid; withdrawal before Valid is illegal (no required behaviour).
- IfRdata/DmemRdata hold their last captured value until overwritten; a write does not modify DmemRdata.
- Stalls are combinational from current request and Valid; no other logic.

## Timing
- Request first seen in IDLE at cycle 0: MemEn in cycle 1.
- Read: MemRdata valid cycle 1+MEM_LAT, Valid cycle 2+MEM_LAT, IDLE cycle 3+MEM_LAT. Read occupancy MEM_LAT+3 cycles.
- Write: MemEn/MemWe cycle 1, DmemValid cycle 2, IDLE cycle 3.
- Competing requester waits through the full transaction and is granted in the next IDLE cycle.
- Reset: state IDLE, MemEn=0, MemWe=0, MemAddr=0, MemWdata=0, IfValid=0, DmemValid=0, IfRdata=0, DmemRdata=0, LastGrant=IF, counter=0. RST asserted mid-transaction abandons it: no Valid pulse, MemEn low in the cycle after the reset edge.
- Stall outputs follow requests even during RST.

## Structure
- Package mem_arb_pkg: state enum (IDLE, ISSUE, WAIT, RESP), owner encoding (OWN_IF=0, OWN_DMEM=1), counter width constant (3 bits).
- One sub-module: mem_lat_counter (load MEM_LAT, decrement, done flag at 1); rest is a single FSM in mem_port_arbiter.

## Test plan
- Reset then IfReq=1, IfAddr=0x100, MEM_LAT=2, memory returns 0xDEADBEEF in cycle 3 -> MemEn cycle 1 only, IfValid cycle 4 with IfRdata=0xDEADBEEF, IfStall high cycles 0-3.
- DmemWEB=0, DmemAddr=0x40, DmemWdata=0x12345678 -> MemEn=MemWe=1 in cycle 1 with those values, DmemValid cycle 2, DmemRdata unchanged.
- IfReq and DmemREB=0 both asserted from cycle 0 after reset -> data granted first, fetch MemEn issued in cycle after DmemValid + 1; next simultaneous pair -> fetch wins (alternation).
- DmemREB=0 and DmemWEB=0 together -> single write transaction, MemWe=1, no read.
- RST pulsed in WAIT state -> no Valid pulse, all outputs at reset values next cycle, subsequent request completes with normal latency.
- MEM_LAT=1 and MEM_LAT=7 back-to-back reads -> Valid at cycle 3 and 9 respectively, requests held high through Valid are not re-issued.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter.
//   arb_state_e : sequencer states
//   owner_e     : which requester owns the current transaction
//   CNT_W       : latency counter width (MEM_LAT up to 7)
package mem_arb_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;
   typedef enum logic {OWN_IF = 1'b0, OWN_DMEM = 1'b1} owner_e;
   localparam int CNT_W = 3;
endpackage

// File: rtl/mem_lat_counter.sv
// Read-latency counter for the memory port arbiter.
//   CLK, RST : clock, synchronous active-high reset
//   load_i   : load MEM_LAT
//   dec_i    : decrement (saturates at 0)
//   done_o   : high while the count is 1, i.e. the cycle MemRdata is valid
module mem_lat_counter
   import mem_arb_pkg::*;
#(
   parameter int MEM_LAT = 2
) (
   input  logic CLK,
   input  logic RST,
   input  logic load_i,
   input  logic dec_i,
   output logic done_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = CNT_W'(MEM_LAT);
      else if (dec_i && cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RST) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign done_o = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and
// the data-memory path. One transaction at a time: IDLE grants, ISSUE
// pulses MemEn, WAIT counts out the read latency, RESP pulses Valid.
//   CLK, RST                    : clock, synchronous active-high reset
//   IfReq/IfAddr                : fetch read request (held until IfValid)
//   IfRdata/IfValid/IfStall     : fetch response and stall
//   DmemREB/DmemWEB             : active-low data read/write strobes
//   DmemAddr/DmemWdata          : data address and store data
//   DmemRdata/DmemValid/DmemStall : data response and stall
//   MemEn/MemWe/MemAddr/MemWdata/MemRdata : memory port
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              IfReq,
   input  logic [ADDR_W-1:0] IfAddr,
   output logic [DATA_W-1:0] IfRdata,
   output logic              IfValid,
   output logic              IfStall,
   input  logic              DmemREB,
   input  logic              DmemWEB,
   input  logic [ADDR_W-1:0] DmemAddr,
   input  logic [DATA_W-1:0] DmemWdata,
   output logic [DATA_W-1:0] DmemRdata,
   output logic              DmemValid,
   output logic              DmemStall,
   output logic              MemEn,
   output logic              MemWe,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [DATA_W-1:0] MemWdata,
   input  logic [DATA_W-1:0] MemRdata
);
   arb_state_e        state_q, state_d;
   owner_e            owner_q, owner_d;
   owner_e            last_q, last_d;
   owner_e            grant;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              if_valid_q, if_valid_d;
   logic              dm_valid_q, dm_valid_d;
   logic              cnt_load, cnt_dec, cnt_done;

   // Both strobes low collapses to a write.
   logic dm_req, dm_wr;
   assign dm_req = ~DmemREB | ~DmemWEB;
   assign dm_wr  = ~DmemWEB;

   mem_lat_counter #(.MEM_LAT(MEM_LAT)) u_lat (
      .CLK    (CLK),
      .RST    (RST),
      .load_i (cnt_load),
      .dec_i  (cnt_dec),
      .done_o (cnt_done)
   );

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      grant       = OWN_IF;
      mem_en_d    = 1'b0;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      if_valid_d  = 1'b0;
      dm_valid_d  = 1'b0;
      cnt_load    = 1'b0;
      cnt_dec     = 1'b0;
      case (state_q)
         IDLE: begin
            if (IfReq || dm_req) begin
               // On a tie the requester not served last time wins.
               if (IfReq && dm_req) grant = (last_q == OWN_IF) ? OWN_DMEM : OWN_IF;
               else if (dm_req)     grant = OWN_DMEM;
               else                 grant = OWN_IF;
               owner_d  = grant;
               state_d  = ISSUE;
               mem_en_d = 1'b1;
               if (grant == OWN_DMEM) begin
                  mem_we_d   = dm_wr;
                  mem_addr_d = DmemAddr;
                  if (dm_wr) mem_wdata_d = DmemWdata;
               end else begin
                  mem_we_d   = 1'b0;
                  mem_addr_d = IfAddr;
               end
            end
         end
         ISSUE: begin
            mem_we_d = 1'b0;
            if (mem_we_q) begin
               state_d    = RESP;
               dm_valid_d = 1'b1;
            end else begin
               state_d  = WAIT;
               cnt_load = 1'b1;
            end
         end
         WAIT: begin
            cnt_dec = 1'b1;
            if (cnt_done) begin
               state_d = RESP;
               if (owner_q == OWN_DMEM) begin
                  dm_rdata_d = MemRdata;
                  dm_valid_d = 1'b1;
               end else begin
                  if_rdata_d = MemRdata;
                  if_valid_d = 1'b1;
               end
            end
         end
         RESP: begin
            // Requests are deliberately ignored here so a request still
            // high during its Valid cycle is not issued a second time.
            last_d  = owner_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         owner_q     <= OWN_IF;
         last_q      <= OWN_IF;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         if_valid_q  <= 1'b0;
         dm_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         if_valid_q  <= if_valid_d;
         dm_valid_q  <= dm_valid_d;
      end
   end

   assign MemEn     = mem_en_q;
   assign MemWe     = mem_we_q;
   assign MemAddr   = mem_addr_q;
   assign MemWdata  = mem_wdata_q;
   assign IfRdata   = if_rdata_q;
   assign DmemRdata = dm_rdata_q;
   assign IfValid   = if_valid_q;
   assign DmemValid = dm_valid_q;
   assign IfStall   = IfReq & ~if_valid_q;
   assign DmemStall = dm_req & ~dm_valid_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiters (MEM_LAT 2, 1, 7) share data-side inputs;
// each has its own IfReq and MemRdata. Cycle 0 is the IDLE cycle in which
// a request is first presented.
module tb_mem_port_arbiter;
   localparam logic [31:0] JUNK = 32'hBAD0BAD0;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        if_req [3];
   logic [31:0] if_addr = '0;
   logic        dm_reb = 1'b1, dm_web = 1'b1;
   logic [31:0] dm_addr = '0, dm_wdata = '0;
   logic [31:0] mrd [3];
   logic [31:0] if_rdata [3], dm_rdata [3], mem_addr [3], mem_wdata [3];
   logic        if_valid [3], if_stall [3], dm_valid [3], dm_stall [3];
   logic        mem_en [3], mem_we [3];

   int n_chk = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : 7;
      mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
         .CLK(CLK), .RST(RST),
         .IfReq(if_req[g]), .IfAddr(if_addr),
         .IfRdata(if_rdata[g]), .IfValid(if_valid[g]), .IfStall(if_stall[g]),
         .DmemREB(dm_reb), .DmemWEB(dm_web),
         .DmemAddr(dm_addr), .DmemWdata(dm_wdata),
         .DmemRdata(dm_rdata[g]), .DmemValid(dm_valid[g]), .DmemStall(dm_stall[g]),
         .MemEn(mem_en[g]), .MemWe(mem_we[g]),
         .MemAddr(mem_addr[g]), .MemWdata(mem_wdata[g]),
         .MemRdata(mrd[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      for (int i = 0; i < 3; i++) if_req[i] = 1'b0;
      dm_reb = 1'b1;
      dm_web = 1'b1;
      tick();
      tick();
      RST = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         if_req[i] = 1'b0;
         mrd[i]    = JUNK;
      end
      do_reset();
      #1;
      chk("rst_memen",   32'(mem_en[0]), 32'd0);
      chk("rst_memwe",   32'(mem_we[0]), 32'd0);
      chk("rst_memaddr", mem_addr[0], 32'd0);
      chk("rst_wdata",   mem_wdata[0], 32'd0);
      chk("rst_ifvld",   32'(if_valid[0]), 32'd0);
      chk("rst_dmvld",   32'(dm_valid[0]), 32'd0);
      chk("rst_ifrd",    if_rdata[0], 32'd0);
      chk("rst_dmrd",    dm_rdata[0], 32'd0);

      // ---- fetch read, MEM_LAT=2 ----
      if_req[0] = 1'b1; if_addr = 32'h100; #1;
      chk("t1c0_stall", 32'(if_stall[0]), 32'd1);
      chk("t1c0_en",    32'(mem_en[0]), 32'd0);
      tick();
      chk("t1c1_en",    32'(mem_en[0]), 32'd1);
      chk("t1c1_we",    32'(mem_we[0]), 32'd0);
      chk("t1c1_addr",  mem_addr[0], 32'h100);
      tick();
      chk("t1c2_en",    32'(mem_en[0]), 32'd0);
      chk("t1c2_stall", 32'(if_stall[0]), 32'd1);
      tick();
      mrd[0] = 32'hDEADBEEF; #1;
      chk("t1c3_vld",   32'(if_valid[0]), 32'd0);
      chk("t1c3_stall", 32'(if_stall[0]), 32'd1);
      tick();
      mrd[0] = JUNK;
      chk("t1c4_vld",   32'(if_valid[0]), 32'd1);
      chk("t1c4_rd",    if_rdata[0], 32'hDEADBEEF);
      chk("t1c4_stall", 32'(if_stall[0]), 32'd0);
      if_req[0] = 1'b0;
      tick();
      chk("t1c5_vld",   32'(if_valid[0]), 32'd0);
      chk("t1c5_en",    32'(mem_en[0]), 32'd0);

      // ---- data write ----
      dm_web = 1'b0; dm_addr = 32'h40; dm_wdata = 32'h12345678; #1;
      chk("t2c0_stall", 32'(dm_stall[0]), 32'd1);
      tick();
      chk("t2c1_en",    32'(mem_en[0]), 32'd1);
      chk("t2c1_we",    32'(mem_we[0]), 32'd1);
      chk("t2c1_addr",  mem_addr[0], 32'h40);
      chk("t2c1_wd",    mem_wdata[0], 32'h12345678);
      tick();
      chk("t2c2_vld",   32'(dm_valid[0]), 32'd1);
      chk("t2c2_rd",    dm_rdata[0], 32'd0);
      chk("t2c2_stall", 32'(dm_stall[0]), 32'd0);
      chk("t2c2_en",    32'(mem_en[0]), 32'd0);
      dm_web = 1'b1;
      tick();
      chk("t2c3_vld",   32'(dm_valid[0]), 32'd0);

      // ---- simultaneous requests: data first, then fetch wins the tie ----
      do_reset();
      if_req[0] = 1'b1; if_addr = 32'h200; dm_reb = 1'b0; dm_addr = 32'h80;
      tick();
      chk("t3c1_en",    32'(mem_en[0]), 32'd1);
      chk("t3c1_addr",  mem_addr[0], 32'h80);
      chk("t3c1_we",    32'(mem_we[0]), 32'd0);
      tick();
      tick();
      mrd[0] = 32'hCAFEF00D;
      tick();
      mrd[0] = JUNK;
      chk("t3c4_dvld",  32'(dm_valid[0]), 32'd1);
      chk("t3c4_drd",   dm_rdata[0], 32'hCAFEF00D);
      chk("t3c4_istl",  32'(if_stall[0]), 32'd1);
      chk("t3c4_ivld",  32'(if_valid[0]), 32'd0);
      dm_reb = 1'b1;
      tick();
      dm_reb = 1'b0; dm_addr = 32'h84; #1;
      chk("t3c5_en",    32'(mem_en[0]), 32'd0);
      chk("t3c5_dstl",  32'(dm_stall[0]), 32'd1);
      tick();
      chk("t3c6_en",    32'(mem_en[0]), 32'd1);
      chk("t3c6_addr",  mem_addr[0], 32'h200);
      tick();
      tick();
      mrd[0] = 32'h11112222;
      tick();
      mrd[0] = JUNK;
      chk("t3c9_ivld",  32'(if_valid[0]), 32'd1);
      chk("t3c9_ird",   if_rdata[0], 32'h11112222);
      chk("t3c9_dvld",  32'(dm_valid[0]), 32'd0);
      if_req[0] = 1'b0;
      tick();
      chk("t3c10_en",   32'(mem_en[0]), 32'd0);
      tick();
      chk("t3c11_en",   32'(mem_en[0]), 32'd1);
      chk("t3c11_addr", mem_addr[0], 32'h84);
      tick();
      tick();
      mrd[0] = 32'h33334444;
      tick();
      mrd[0] = JUNK;
      chk("t3c14_dvld", 32'(dm_valid[0]), 32'd1);
      chk("t3c14_drd",  dm_rdata[0], 32'h33334444);
      dm_reb = 1'b1;
      tick();

      // ---- both strobes low: one write, load data untouched ----
      dm_reb = 1'b0; dm_web = 1'b0; dm_addr = 32'h90; dm_wdata = 32'hA5A5A5A5;
      tick();
      chk("t4c1_en",    32'(mem_en[0]), 32'd1);
      chk("t4c1_we",    32'(mem_we[0]), 32'd1);
      chk("t4c1_addr",  mem_addr[0], 32'h90);
      chk("t4c1_wd",    mem_wdata[0], 32'hA5A5A5A5);
      tick();
      chk("t4c2_vld",   32'(dm_valid[0]), 32'd1);
      chk("t4c2_rd",    dm_rdata[0], 32'h33334444);
      chk("t4c2_en",    32'(mem_en[0]), 32'd0);
      dm_reb = 1'b1; dm_web = 1'b1;
      tick();
      chk("t4c3_vld",   32'(dm_valid[0]), 32'd0);
      chk("t4c3_en",    32'(mem_en[0]), 32'd0);

      // ---- reset while waiting for read data ----
      if_req[0] = 1'b1; if_addr = 32'h300;
      tick();
      chk("t5c1_en",    32'(mem_en[0]), 32'd1);
      tick();
      RST = 1'b1; #1;
      chk("t5c2_stall", 32'(if_stall[0]), 32'd1);
      tick();
      mrd[0] = 32'h55556666; #1;
      chk("t5c3_en",    32'(mem_en[0]), 32'd0);
      chk("t5c3_addr",  mem_addr[0], 32'd0);
      chk("t5c3_wd",    mem_wdata[0], 32'd0);
      chk("t5c3_vld",   32'(if_valid[0]), 32'd0);
      chk("t5c3_ird",   if_rdata[0], 32'd0);
      chk("t5c3_drd",   dm_rdata[0], 32'd0);
      chk("t5c3_stall", 32'(if_stall[0]), 32'd1);
      RST = 1'b0;
      tick();
      mrd[0] = JUNK;
      chk("t5n1_en",    32'(mem_en[0]), 32'd1);
      chk("t5n1_addr",  mem_addr[0], 32'h300);
      chk("t5n1_vld",   32'(if_valid[0]), 32'd0);
      tick();
      chk("t5n2_vld",   32'(if_valid[0]), 32'd0);
      tick();
      mrd[0] = 32'h77778888;
      tick();
      mrd[0] = JUNK;
      chk("t5n4_vld",   32'(if_valid[0]), 32'd1);
      chk("t5n4_rd",    if_rdata[0], 32'h77778888);
      if_req[0] = 1'b0;
      tick();
      chk("t5n5_vld",   32'(if_valid[0]), 32'd0);

      // ---- MEM_LAT=1 and MEM_LAT=7, request held through Valid ----
      do_reset();
      if_req[1] = 1'b1; if_req[2] = 1'b1; if_addr = 32'h400;
      tick();
      chk("t6c1_en1",   32'(mem_en[1]), 32'd1);
      chk("t6c1_en7",   32'(mem_en[2]), 32'd1);
      tick();
      mrd[1] = 32'hAAAA0001; #1;
      chk("t6c2_vld1",  32'(if_valid[1]), 32'd0);
      tick();
      mrd[1] = JUNK;
      chk("t6c3_vld1",  32'(if_valid[1]), 32'd1);
      chk("t6c3_rd1",   if_rdata[1], 32'hAAAA0001);
      tick();
      if_req[1] = 1'b0;
      chk("t6c4_vld1",  32'(if_valid[1]), 32'd0);
      chk("t6c4_en1",   32'(mem_en[1]), 32'd0);
      tick();
      chk("t6c5_en1",   32'(mem_en[1]), 32'd0);
      tick();
      tick();
      tick();
      mrd[2] = 32'hBBBB0007; #1;
      chk("t6c8_vld7",  32'(if_valid[2]), 32'd0);
      tick();
      mrd[2] = JUNK;
      chk("t6c9_vld7",  32'(if_valid[2]), 32'd1);
      chk("t6c9_rd7",   if_rdata[2], 32'hBBBB0007);
      tick();
      if_req[2] = 1'b0;
      chk("t6c10_vld7", 32'(if_valid[2]), 32'd0);
      chk("t6c10_en7",  32'(mem_en[2]), 32'd0);
      tick();
      chk("t6c11_en7",  32'(mem_en[2]), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
